rv_boot_ctrl: RTL and testbench

Parametrised boot/run controller for the rv_core family, covering one to NUM_HARTS cores.
- Streams a program image into instruction memory over a valid/ready load port.
- Holds the cores in reset for a programmable number of cycles after the last instruction write, then releases the selected harts.
- Monitors each hart's data-memory write bus for a tohost pass/fail write, with a global timeout.
- Replaces fixed bench-side memory preloading and reset sequencing with synthesizable, reusable logic for FPGA and simulation.

---
 rtl/rv_boot_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_rv_boot_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_boot_ctrl.sv
// rv_boot_ctrl: streams an image into imem, sequences core reset,
// and watches tohost writes for a pass/fail/timeout result.
module rv_boot_ctrl #(
  parameter int unsigned          ADDR_W      = 10,
  parameter int unsigned          DATA_W      = 32,
  parameter int unsigned          NUM_HARTS   = 1,
  parameter int unsigned          RST_HOLD    = 4,
  parameter int unsigned          TIMEOUT     = 100000,
  parameter logic [DATA_W-1:0]    TOHOST_ADDR = 'h1000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          ld_valid,
  output logic                          ld_ready,
  input  logic [DATA_W-1:0]             ld_data,
  input  logic                          ld_last,
  output logic                          imem_we,
  output logic [ADDR_W-1:0]             imem_addr,
  output logic [DATA_W-1:0]             imem_wdata,
  input  logic [NUM_HARTS-1:0]          hart_en,
  output logic [NUM_HARTS-1:0]          core_rstn,
  input  logic [NUM_HARTS-1:0]          dmem_we,
  input  logic [NUM_HARTS*DATA_W-1:0]   dmem_addr,
  input  logic [NUM_HARTS*DATA_W-1:0]   dmem_wdata,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic                          timeout,
  output logic [DATA_W-1:0]             fail_code,
  output logic [ADDR_W:0]               word_cnt
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_HOLD, S_RUN, S_DONE
  } state_t;

  state_t                 state, state_n;
  logic                   fin;
  logic [31:0]            hcnt;
  logic [31:0]            rcnt;
  logic [NUM_HARTS-1:0]   pbits;
  logic [NUM_HARTS-1:0]   pbits_n;
  logic [NUM_HARTS-1:0]   hit_pass;
  logic                   fail_any;
  logic [DATA_W-1:0]      fail_val;
  logic                   accept;
  logic                   wr_fin;
  logic                   rel;
  logic                   all_pass;
  logic                   tmo;

  always_comb begin
    state_n  = state;
    ld_ready = 1'b0;
    busy     = 1'b0;
    hit_pass = '0;
    fail_any = 1'b0;
    fail_val = '0;
    // Descending scan so the lowest failing hart is the one kept.
    for (int i = NUM_HARTS - 1; i >= 0; i--) begin
      if (dmem_we[i] && core_rstn[i] &&
          dmem_addr[i*DATA_W +: DATA_W] == TOHOST_ADDR) begin
        if (dmem_wdata[i*DATA_W +: DATA_W] == DATA_W'(1)) begin
          hit_pass[i] = 1'b1;
        end else if (dmem_wdata[i*DATA_W +: DATA_W] != '0) begin
          fail_any = 1'b1;
          fail_val = dmem_wdata[i*DATA_W +: DATA_W];
        end
      end
    end
    pbits_n  = pbits | hit_pass;
    all_pass = ((pbits_n & core_rstn) == core_rstn);
    tmo      = ((rcnt + 32'd1) == TIMEOUT);
    wr_fin   = imem_we & fin;
    rel      = (state == S_LOAD && wr_fin && RST_HOLD == 1) ||
               (state == S_HOLD && hcnt == RST_HOLD - 1);
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) state_n = S_LOAD;
      end
      S_LOAD: begin
        busy     = 1'b1;
        ld_ready = !fin && (word_cnt < DEPTH);
        if (wr_fin) begin
          if (!rel)          state_n = S_HOLD;
          else if (|hart_en) state_n = S_RUN;
          else               state_n = S_DONE;
        end
      end
      S_HOLD: begin
        busy = 1'b1;
        if (rel) state_n = (|hart_en) ? S_RUN : S_DONE;
      end
      S_RUN: begin
        busy = 1'b1;
        if (fail_any || all_pass || tmo) state_n = S_DONE;
      end
      default: state_n = S_IDLE;
    endcase
    accept = ld_valid & ld_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_rstn  <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
      timeout    <= 1'b0;
      fail_code  <= '0;
      word_cnt   <= '0;
      fin        <= 1'b0;
      hcnt       <= '0;
      rcnt       <= '0;
      pbits      <= '0;
    end else begin
      imem_we <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            word_cnt  <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            fail_code <= '0;
            fin       <= 1'b0;
            hcnt      <= '0;
            rcnt      <= '0;
            pbits     <= '0;
          end
        end
        S_LOAD: begin
          if (accept) begin
            imem_we    <= 1'b1;
            imem_addr  <= word_cnt[ADDR_W-1:0];
            imem_wdata <= ld_data;
            word_cnt   <= word_cnt + 1'b1;
            fin        <= ld_last || ((word_cnt + 1'b1) == DEPTH);
          end
          if (wr_fin) hcnt <= 32'd1;
        end
        S_HOLD: hcnt <= hcnt + 32'd1;
        S_RUN: begin
          rcnt  <= rcnt + 32'd1;
          pbits <= pbits_n;
          if (fail_any) begin
            done      <= 1'b1;
            fail_code <= fail_val;
            core_rstn <= '0;
          end else if (all_pass) begin
            done      <= 1'b1;
            pass      <= 1'b1;
            core_rstn <= '0;
          end else if (tmo) begin
            done      <= 1'b1;
            timeout   <= 1'b1;
            core_rstn <= '0;
          end
        end
        default: ;
      endcase
      // With no harts selected there is nothing to run.
      if (rel) begin
        core_rstn <= hart_en;
        if (hart_en == '0) begin
          done      <= 1'b1;
          fail_code <= '1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rv_boot_ctrl.sv
// tb_rv_boot_ctrl: directed bench for rv_boot_ctrl
// (2-bit imem address, two harts, short timeout).
module tb_rv_boot_ctrl;

  localparam int AW = 2;
  localparam int DW = 32;
  localparam int NH = 2;
  localparam logic [31:0] TH = 32'h0000_1000;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           ld_valid = 1'b0;
  logic           ld_ready;
  logic [DW-1:0]  ld_data = '0;
  logic           ld_last = 1'b0;
  logic           imem_we;
  logic [AW-1:0]  imem_addr;
  logic [DW-1:0]  imem_wdata;
  logic [NH-1:0]  hart_en = '0;
  logic [NH-1:0]  core_rstn;
  logic [NH-1:0]  dmem_we = '0;
  logic [NH*DW-1:0] dmem_addr = '0;
  logic [NH*DW-1:0] dmem_wdata = '0;
  logic           busy, done, pass, timeout;
  logic [DW-1:0]  fail_code;
  logic [AW:0]    word_cnt;

  int errors = 0;
  int checks = 0;
  int nwr = 0;
  int n0;
  logic [DW-1:0] img [4];

  rv_boot_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_HARTS(NH),
    .RST_HOLD(4), .TIMEOUT(100), .TOHOST_ADDR(TH)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_last(ld_last),
    .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .hart_en(hart_en),
    .core_rstn(core_rstn), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .fail_code(fail_code),
    .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (imem_we === 1'b1) nwr <= nwr + 1;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input int a,
                        input logic [DW-1:0] d);
    chk({tag, "_we"}, imem_we, 1);
    chk({tag, "_addr"}, imem_addr, a);
    chk({tag, "_data"}, imem_wdata, d);
  endtask

  // Start a session, load one word, step to the first RUN cycle.
  task automatic boot(input logic [NH-1:0] en);
    hart_en = en;
    start = 1'b1;
    step();
    start = 1'b0;
    ld_valid = 1'b1;
    ld_last = 1'b1;
    ld_data = 32'h0000_006f;
    step();
    ld_valid = 1'b0;
    ld_last = 1'b0;
    repeat (4) step();
    chk("boot_rstn", core_rstn, en);
  endtask

  task automatic tohost(input logic [NH-1:0] we,
                        input logic [DW-1:0] d1,
                        input logic [DW-1:0] d0);
    dmem_we = we;
    dmem_addr = {TH, TH};
    dmem_wdata = {d1, d0};
  endtask

  initial begin
    img[0] = 32'h0000_0013;
    img[1] = 32'h0010_0093;
    img[2] = 32'h0020_0113;
    img[3] = 32'h0000_0073;

    // Reset state
    step();
    step();
    chk("rst_rstn", core_rstn, 0);
    chk("rst_ready", ld_ready, 0);
    chk("rst_we", imem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_res", {pass, timeout}, 0);
    chk("rst_fc", fail_code, 0);
    chk("rst_wc", word_cnt, 0);
    rst = 1'b0;
    step();

    // 1: four-beat image, continuous valid
    hart_en = 2'b01;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t1_busy", busy, 1);
    chk("t1_ready", ld_ready, 1);
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1;
      ld_data = img[i];
      ld_last = (i == 3);
      step();
      chk_wr("t1_wr", i, img[i]);
    end
    ld_valid = 1'b0;
    ld_last = 1'b0;
    chk("t1_wc", word_cnt, 4);
    chk("t1_ready_lo", ld_ready, 0);
    repeat (3) step();
    chk("t1_hold_rstn", core_rstn, 0);
    chk("t1_hold_we", imem_we, 0);
    step();
    chk("t1_rel_rstn", core_rstn, 2'b01);
    tohost(2'b11, 32'h1, 32'h1);
    step();
    tohost(2'b00, 0, 0);
    chk("t1_done", done, 1);
    chk("t1_pass", pass, 1);
    chk("t1_busy_lo", busy, 0);
    chk("t1_rstn_lo", core_rstn, 0);

    // 2: gapped valid, reset after two writes
    start = 1'b1;
    step();
    start = 1'b0;
    ld_valid = 1'b1;
    ld_data = img[0];
    step();
    chk_wr("t2_wr0", 0, img[0]);
    ld_valid = 1'b0;
    step();
    chk("t2_gap_we", imem_we, 0);
    chk("t2_gap_ready", ld_ready, 1);
    ld_valid = 1'b1;
    ld_data = img[1];
    step();
    chk_wr("t2_wr1", 1, img[1]);
    chk("t2_wc", word_cnt, 2);
    ld_valid = 1'b0;
    step();
    ld_valid = 1'b1;
    ld_data = img[2];
    rst = 1'b1;
    step();
    chk("t2_rst_we", imem_we, 0);
    chk("t2_rst_wc", word_cnt, 0);
    chk("t2_rst_busy", busy, 0);
    chk("t2_rst_ready", ld_ready, 0);
    chk("t2_rst_done", done, 0);
    chk("t2_rst_pass", pass, 0);
    n0 = nwr;
    rst = 1'b0;
    repeat (3) step();
    chk("t2_no_wr", nwr - n0, 0);
    ld_valid = 1'b0;

    // 3: six beats, no ld_last, 4-word imem; no harts selected
    hart_en = 2'b00;
    n0 = nwr;
    start = 1'b1;
    step();
    start = 1'b0;
    ld_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ld_data = 32'h100 + i;
      step();
      if (i < 4) chk_wr("t3_wr", i, 32'h100 + i);
      if (i == 3) chk("t3_ready_lo", ld_ready, 0);
    end
    ld_valid = 1'b0;
    chk("t3_nwr", nwr - n0, 4);
    chk("t3_wc", word_cnt, 4);
    chk("t3_hold", {busy, core_rstn}, 3'b100);
    repeat (2) step();
    chk("t3_done", done, 1);
    chk("t3_pass", pass, 0);
    chk("t3_fc", fail_code, 32'hFFFF_FFFF);

    // 4: two harts pass, hart1 twenty cycles after hart0
    boot(2'b11);
    chk("t4_wc", word_cnt, 1);
    tohost(2'b11, 32'h7, 32'h1);
    dmem_addr[DW +: DW] = TH + 32'h4;
    step();
    tohost(2'b00, 0, 0);
    chk("t4_nohit", done, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t4_start_ign", {busy, word_cnt}, 4'b1001);
    repeat (8) step();
    tohost(2'b01, 0, 0);
    step();
    tohost(2'b00, 0, 0);
    repeat (9) step();
    chk("t4_wait", done, 0);
    tohost(2'b10, 32'h1, 0);
    step();
    tohost(2'b00, 0, 0);
    chk("t4_done", done, 1);
    chk("t4_pass", pass, 1);
    chk("t4_to", timeout, 0);
    chk("t4_rstn", core_rstn, 0);

    // 5: fail codes, lowest hart wins
    boot(2'b11);
    tohost(2'b11, 32'h7, 32'h5);
    step();
    tohost(2'b00, 0, 0);
    chk("t5_done", done, 1);
    chk("t5_pass", pass, 0);
    chk("t5_fc", fail_code, 32'h5);
    boot(2'b11);
    tohost(2'b10, 32'h7, 0);
    step();
    tohost(2'b00, 0, 0);
    chk("t5_fc1", fail_code, 32'h7);
    boot(2'b01);
    tohost(2'b11, 32'h7, 32'h1);
    step();
    tohost(2'b00, 0, 0);
    chk("t5_dis", {done, pass}, 2'b11);
    chk("t5_dis_fc", fail_code, 0);

    // 6: timeout at RUN cycle 100, then a pass on that cycle
    boot(2'b01);
    repeat (99) step();
    chk("t6_pre", {done, busy}, 2'b01);
    step();
    chk("t6_done", done, 1);
    chk("t6_to", timeout, 1);
    chk("t6_pass", pass, 0);
    boot(2'b01);
    repeat (99) step();
    tohost(2'b01, 0, 32'h1);
    step();
    tohost(2'b00, 0, 0);
    chk("t6v_done", done, 1);
    chk("t6v_pass", pass, 1);
    chk("t6v_to", timeout, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
